lc3b_write_buffer: RTL
======================

Name: lc3b_write_buffer

Overview:
Parametrised eviction write buffer between the L2 cache and physical memory. It absorbs dirty-line writebacks in a DEPTH-entry FIFO so L2 misses are not blocked by writebacks. It serves reads that hit a buffered line directly, forwards other reads to memory, and drains entries to memory when memory is idle. Both sides use the codebase's hold-until-resp line interface.

Parameters:
LINE_W, 128, line width in bits (lc3b_line)
ADDR_W, 16, byte address width
OFFSET_W, 4, line offset bits; entry key is address[ADDR_W-1:OFFSET_W]
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
up_read  in  1  L2 line read request, held until up_resp
up_write  in  1  L2 writeback request, held until up_resp; never asserted with up_read
up_address  in  ADDR_W  request address; offset bits ignored
up_wdata  in  LINE_W  writeback line
up_rdata  out  LINE_W  read line, valid when up_resp=1
up_resp  out  1  one-cycle completion pulse
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_address  out  ADDR_W  line address, offset bits zero
mem_wdata  out  LINE_W  line to write
mem_rdata  in  LINE_W  memory read data
mem_resp  in  1  memory completion pulse

Behaviour:
- Reset (async, reset_n=0): FIFO empty, state IDLE. up_resp, mem_read, mem_write, up_rdata, mem_address and mem_wdata are all 0.
- All outputs are registered. Each entry holds key[ADDR_W-OFFSET_W], data[LINE_W] and valid. Head/tail pointers wrap modulo DEPTH. count is in 0..DEPTH.
- States: IDLE, UP_ACK, RD_MEM, WR_MEM.
- Transitions out of IDLE, first match wins:
  1. up_read and key hits a valid entry: load up_rdata from the newest matching entry, go to UP_ACK.
  2. up_read with no hit: go to RD_MEM and assert mem_read at the line address.
  3. up_write and count<DEPTH: push at tail, go to UP_ACK.
  4. count>0: go to WR_MEM and drive the head entry.
  5. Otherwise stay in IDLE.
- UP_ACK: up_resp=1 for exactly one cycle, then IDLE. Read-hit latency and write-accept latency are both 2 cycles from request.
- RD_MEM: hold mem_read until mem_resp. On mem_resp, capture mem_rdata into up_rdata and go to UP_ACK.
- WR_MEM: hold mem_write, mem_address and mem_wdata until mem_resp. On mem_resp, pop head and go to IDLE.
- Full (count=DEPTH) with up_write pending: the request stalls with no up_resp. The drain proceeds, and the push is accepted in the IDLE cycle after the pop.
- A write that is already in flight in WR_MEM is never aborted by a new up_read. The read waits.
- Reads hitting the buffer never go to memory. Read data is therefore always the newest copy.
- Reset mid-transaction discards all entries and drops mem_read/mem_write immediately. Memory is expected to be reset together with this block.
- A read never pops an entry; only a completed WR_MEM does.

Optional Feature:
Macro LC3B_WB_COALESCE_EN.
- Defined: an up_write whose key matches a valid entry overwrites that entry's data in place. count is unchanged, and the write is accepted even when full. An entry currently being written in WR_MEM is excluded from the match, so the write takes a new slot instead.
- Undefined: every up_write takes a new slot; duplicate keys are allowed and the newest match wins on reads.

Decomposition:
- Package lc3b_types gains:
  - lc3b_wb_state enum {IDLE, UP_ACK, RD_MEM, WR_MEM}
  - typedef lc3b_line_addr logic [11:0]
- Natural sub-module: lc3b_wb_match, combinational. It compares the key against all entries and returns hit plus the newest matching index, searching from tail-1 backward to head.

Test Plan:
1. After reset, up_write addr 0x1230, data A -> up_resp at cycle 2, then mem_write addr 0x1230 data A. Entry pops on mem_resp; count returns to 0.
2. Write 0x4000=B, then up_read 0x400A before drain -> up_rdata=B, up_resp at cycle 2, no mem_read issued.
3. up_read 0x8000 with buffer empty, mem_resp after 5 cycles with data C -> mem_read held 5 cycles, up_rdata=C, up_resp one cycle later.
4. Fill 4 writes at 0x0000/0x0010/0x0020/0x0030, then a fifth at 0x0040 -> no up_resp until the first mem_resp pops 0x0000. Memory writes then occur in FIFO order.
5. Writes 0x2000=D then 0x2000=E, read 0x2000 -> returns E. With COALESCE_EN, count=1 and there is one memory write; without it, count=2 and there are two memory writes in order D, E.
6. Assert reset_n=0 mid-WR_MEM -> mem_write drops the same cycle, count=0, all outputs 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types, including the eviction write buffer's
// FSM state encoding and the line-address key type.
package lc3b_types;

    localparam int unsigned LC3B_LINE_W      = 128;
    localparam int unsigned LC3B_LINE_ADDR_W = 12;

    typedef logic [LC3B_LINE_W-1:0]      lc3b_line;
    typedef logic [LC3B_LINE_ADDR_W-1:0] lc3b_line_addr;

    typedef enum logic [1:0] {
        IDLE,
        UP_ACK,
        RD_MEM,
        WR_MEM
    } lc3b_wb_state;

endpackage

// File: rtl/lc3b_write_buffer_if.sv
// Hold-until-resp line interface: the master holds read or write until a
// one-cycle resp pulse from the slave.
interface lc3b_write_buffer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
);

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );

endinterface

// File: rtl/lc3b_wb_match.sv
// Combinational key lookup over the write-buffer entries. It returns the newest
// matching slot, searching backward from tail-1.
module lc3b_wb_match #(
    parameter int unsigned KEY_W = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic [KEY_W-1:0]         key_i,
    input  logic [KEY_W-1:0]         keys_i [DEPTH],
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [$clog2(DEPTH)-1:0] tail_i,
    input  logic                     excl_en_i,
    input  logic [$clog2(DEPTH)-1:0] excl_idx_i,
    output logic                     hit_c_o,
    output logic [$clog2(DEPTH)-1:0] idx_c_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] probe;

    // i = DEPTH wraps to tail itself, which is the head slot when the FIFO is full.
    always_comb begin
        hit_c_o = 1'b0;
        idx_c_o = '0;
        probe   = '0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            probe = tail_i - PTR_W'(i);
            if (!hit_c_o && valid_i[probe] && (keys_i[probe] == key_i)
                && !(excl_en_i && (probe == excl_idx_i))) begin
                hit_c_o = 1'b1;
                idx_c_o = probe;
            end
        end
    end

endmodule

// File: rtl/lc3b_write_buffer.sv
// Eviction write buffer between L2 and memory: a FIFO of dirty lines, local
// read hits, and idle-time drain. Build option LC3B_WB_COALESCE_EN merges rewrites.
module lc3b_write_buffer
    import lc3b_types::*;
#(
    parameter int unsigned LINE_W   = 128,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    lc3b_write_buffer_if.slave  up,
    lc3b_write_buffer_if.master mem
);

    localparam int unsigned KEY_W = ADDR_W - OFFSET_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    lc3b_wb_state      state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [KEY_W-1:0]  key_q [DEPTH];
    logic [KEY_W-1:0]  key_d [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [LINE_W-1:0] data_d [DEPTH];

    logic [LINE_W-1:0] up_rdata_q, up_rdata_d;
    logic              up_resp_q, up_resp_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0] line_addr_c;
    logic [KEY_W-1:0]  up_key_c;
    logic              hit_c;
    logic [PTR_W-1:0]  hit_idx_c;
    logic              coalesce_c;

    assign line_addr_c = up.address & ~ADDR_W'((1 << OFFSET_W) - 1);
    assign up_key_c    = KEY_W'(line_addr_c >> OFFSET_W);

    lc3b_wb_match #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH)
    ) u_match (
        .key_i      (up_key_c),
        .keys_i     (key_q),
        .valid_i    (valid_q),
        .tail_i     (tail_q),
        .excl_en_i  (state_q == WR_MEM),
        .excl_idx_i (head_q),
        .hit_c_o    (hit_c),
        .idx_c_o    (hit_idx_c)
    );

`ifdef LC3B_WB_COALESCE_EN
    assign coalesce_c = up.write && hit_c;
`else
    assign coalesce_c = 1'b0;
`endif

    // Next-state and registered-output logic; first matching IDLE rule wins.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        key_d       = key_q;
        data_d      = data_q;
        up_rdata_d  = up_rdata_q;
        up_resp_d   = 1'b0;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (up.read && hit_c) begin
                    up_rdata_d = data_q[hit_idx_c];
                    up_resp_d  = 1'b1;
                    state_d    = UP_ACK;
                end else if (up.read) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = line_addr_c;
                    state_d    = RD_MEM;
                end else if (coalesce_c) begin
                    data_d[hit_idx_c] = up.wdata;
                    up_resp_d         = 1'b1;
                    state_d           = UP_ACK;
                end else if (up.write && (count_q != CNT_W'(DEPTH))) begin
                    key_d[tail_q]   = up_key_c;
                    data_d[tail_q]  = up.wdata;
                    valid_d[tail_q] = 1'b1;
                    tail_d          = tail_q + PTR_W'(1);
                    count_d         = count_q + CNT_W'(1);
                    up_resp_d       = 1'b1;
                    state_d         = UP_ACK;
                end else if (count_q != '0) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = {key_q[head_q], OFFSET_W'(0)};
                    mem_wdata_d = data_q[head_q];
                    state_d     = WR_MEM;
                end
            end
            UP_ACK: state_d = IDLE;
            RD_MEM: begin
                if (mem.resp) begin
                    mem_read_d = 1'b0;
                    up_rdata_d = mem.rdata;
                    up_resp_d  = 1'b1;
                    state_d    = UP_ACK;
                end
            end
            WR_MEM: begin
                if (mem.resp) begin
                    mem_write_d     = 1'b0;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PTR_W'(1);
                    count_d         = count_q - CNT_W'(1);
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            up_rdata_q  <= '0;
            up_resp_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            up_rdata_q  <= up_rdata_d;
            up_resp_q   <= up_resp_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Entry payload needs no reset: valid_q qualifies every use.
    always_ff @(posedge clk) begin
        key_q  <= key_d;
        data_q <= data_d;
    end

    assign up.rdata   = up_rdata_q;
    assign up.resp    = up_resp_q;
    assign mem.read   = mem_read_q;
    assign mem.write  = mem_write_q;
    assign mem.address = mem_addr_q;
    assign mem.wdata  = mem_wdata_q;

endmodule
